matrix_serial_receiver: RTL and testbench

- Receive end of the 16x16 LED-matrix serial link. Deserializes the sclk / serial_data / rclk / clear stream that drives the 74HC595-style anode+cathode shift chain.
- Decodes each latched 32-bit word into one active row of 16 pixels and accumulates the 4-pass density scan into a 2-bit-per-pixel frame.
- Used as a display emulator and a loopback checker for the matrix driver on the Tang Primer 20K.

---
 rtl/matrix_serial_receiver.sv | 168 ++++++++++++++++
 tb/tb_matrix_serial_receiver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_serial_receiver.sv
// Receive side of the 16x16 LED-matrix serial link: deserializes the 595-style
// shift/latch stream and accumulates the 4-pass density scan into a 2-bit frame.
module matrix_serial_receiver #(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned LATCHES_PER_FRAME = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        serial_data,
    input  logic        rclk,
    input  logic        clear,
    input  logic        err_clr,
    input  logic [3:0]  rd_row,
    input  logic [3:0]  rd_col,
    output logic [1:0]  rd_pix,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        framing_err,
    output logic        select_err
);

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned DIM           = 16;
    localparam int unsigned PIX_W         = 2;
    localparam int unsigned CNT_W         = 6;
    localparam int unsigned CNT_SAT       = 33;
    localparam int unsigned LCNT_W        = $clog2(LATCHES_PER_FRAME + 1);
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;

    // Input synchronizers plus one delay flop on the clocks for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] rclk_sync;
    logic [SYNC_STAGES-1:0] clear_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sclk_d;
    logic                   rclk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            rclk_sync  <= '0;
            clear_sync <= '0;
            data_sync  <= '0;
            sclk_d     <= 1'b0;
            rclk_d     <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            rclk_sync  <= {rclk_sync[SYNC_STAGES-2:0], rclk};
            clear_sync <= {clear_sync[SYNC_STAGES-2:0], clear};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], serial_data};
            sclk_d     <= sclk_sync[SYNC_STAGES-1];
            rclk_d     <= rclk_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_rise_c;
    logic rclk_rise_c;
    logic clear_n_c;
    logic data_c;

    assign sclk_rise_c = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    assign rclk_rise_c = rclk_sync[SYNC_STAGES-1] & ~rclk_d;
    assign clear_n_c   = clear_sync[SYNC_STAGES-1];
    assign data_c      = data_sync[SYNC_STAGES-1];

    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bitcnt;
    logic [WORD_W-1:0] shreg_nxt_c;
    logic [CNT_W-1:0]  bitcnt_nxt_c;

    // Shift register next value; clear dominates a coincident shift
    always_comb begin
        shreg_nxt_c  = shreg;
        bitcnt_nxt_c = bitcnt;
        if (!clear_n_c) begin
            shreg_nxt_c  = '0;
            bitcnt_nxt_c = '0;
        end else if (sclk_rise_c) begin
            shreg_nxt_c = {shreg[WORD_W-2:0], data_c};
            if (bitcnt != CNT_W'(CNT_SAT)) begin
                bitcnt_nxt_c = bitcnt + CNT_W'(1);
            end
        end
    end

    logic [DIM-1:0] anode_c;
    logic [DIM-1:0] cathode_c;
    logic           frame_ok_c;
    logic           select_ok_c;
    logic           valid_latch_c;
    logic [3:0]     row_c;

    assign anode_c       = shreg_nxt_c[WORD_W-1:DIM];
    assign cathode_c     = shreg_nxt_c[DIM-1:0];
    assign frame_ok_c    = (bitcnt_nxt_c == CNT_W'(WORD_W));
    assign select_ok_c   = $onehot(~cathode_c);
    assign valid_latch_c = rclk_rise_c & frame_ok_c & select_ok_c;

    // Row k is selected by the single low cathode bit at word[15-k]
    always_comb begin
        row_c = '0;
        for (int k = 0; k < DIM; k++) begin
            if (!cathode_c[DIM-1-k]) begin
                row_c = 4'(k);
            end
        end
    end

    logic [DIM-1:0][DIM-1:0][PIX_W-1:0] acc;
    logic [DIM-1:0][DIM-1:0][PIX_W-1:0] acc_nxt_c;
    logic [DIM-1:0][DIM-1:0][PIX_W-1:0] frame_buf;
    logic [LCNT_W-1:0]                  latch_cnt;
    logic [LCNT_W-1:0]                  latch_cnt_nxt_c;
    logic                               commit_c;

    assign commit_c = (latch_cnt == LCNT_W'(LATCHES_PER_FRAME));

    // Saturating accumulate; a latch in the commit cycle lands in the cleared buffer
    always_comb begin
        acc_nxt_c       = commit_c ? '0 : acc;
        latch_cnt_nxt_c = (commit_c ? '0 : latch_cnt) + LCNT_W'(valid_latch_c);
        if (valid_latch_c) begin
            for (int x = 0; x < DIM; x++) begin
                if (anode_c[x] && (acc_nxt_c[row_c][x] != PIX_MAX)) begin
                    acc_nxt_c[row_c][x] = acc_nxt_c[row_c][x] + PIX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            bitcnt      <= '0;
            word        <= '0;
            word_valid  <= 1'b0;
            acc         <= '0;
            latch_cnt   <= '0;
            frame_buf   <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            framing_err <= 1'b0;
            select_err  <= 1'b0;
        end else begin
            shreg       <= shreg_nxt_c;
            bitcnt      <= rclk_rise_c ? '0 : bitcnt_nxt_c;
            word_valid  <= rclk_rise_c;
            acc         <= acc_nxt_c;
            latch_cnt   <= latch_cnt_nxt_c;
            frame_done  <= commit_c;
            frame_count <= frame_count + 8'(commit_c);
            framing_err <= (framing_err & ~err_clr) | (rclk_rise_c & ~frame_ok_c);
            select_err  <= (select_err & ~err_clr) | (rclk_rise_c & ~select_ok_c);
            if (rclk_rise_c) begin
                word <= shreg_nxt_c;
            end
            if (commit_c) begin
                frame_buf <= acc;
            end
        end
    end

    assign rd_pix = frame_buf[rd_row][rd_col];

endmodule

// File: tb/tb_matrix_serial_receiver.sv
// Directed bench for matrix_serial_receiver: drives the serial link pin by pin
// and checks words, error flags, frame pulses and committed pixels.
module tb_matrix_serial_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        serial_data;
    logic        rclk;
    logic        clear;
    logic        err_clr;
    logic [3:0]  rd_row;
    logic [3:0]  rd_col;
    logic [1:0]  rd_pix;
    logic [31:0] word;
    logic        word_valid;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        framing_err;
    logic        select_err;

    int tests = 0;
    int fails = 0;
    int wv_cnt = 0;
    int fd_cnt = 0;
    int fd_base;
    logic [31:0] tb_shreg;
    logic [31:0] v31;

    matrix_serial_receiver #(.SYNC_STAGES(2), .LATCHES_PER_FRAME(64)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .serial_data(serial_data),
        .rclk(rclk), .clear(clear), .err_clr(err_clr),
        .rd_row(rd_row), .rd_col(rd_col), .rd_pix(rd_pix),
        .word(word), .word_valid(word_valid), .frame_done(frame_done),
        .frame_count(frame_count), .framing_err(framing_err), .select_err(select_err)
    );

    always #5 clk = ~clk;

    // Pulse counters; high-sample counts also catch pulses wider than one cycle
    always @(negedge clk) begin
        if (word_valid) wv_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input logic [15:0] anode, input logic [3:0] row);
        logic [15:0] sel;
        sel = 16'h8000 >> row;
        return {anode, ~sel};
    endfunction

    task automatic send_bit(input logic b);
        serial_data = b;
        sclk = 1'b0;
        step(2);
        sclk = 1'b1;
        step(2);
        tb_shreg = {tb_shreg[30:0], b};
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic latch_pulse();
        sclk = 1'b0;
        step(2);
        rclk = 1'b1;
        step(3);
        rclk = 1'b0;
        step(3);
    endtask

    task automatic send_latch(input logic [31:0] w);
        send_word(w);
        latch_pulse();
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(1);
    endtask

    // Expect value v in column col of every row and 0 everywhere else
    task automatic check_frame(input string tag, input int col, input logic [1:0] v);
        int bad;
        logic [1:0] exp;
        bad = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                rd_row = 4'(r);
                rd_col = 4'(c);
                #1;
                exp = (c == col) ? v : 2'd0;
                if (rd_pix !== exp) bad++;
            end
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        sclk = 1'b0;
        rclk = 1'b0;
        clear = 1'b1;
        serial_data = 1'b0;
        err_clr = 1'b0;
        rd_row = '0;
        rd_col = '0;
        tb_shreg = '0;
        step(3);
        chk("in_reset_word", word, 32'h0);
        chk("in_reset_fcnt", 32'(frame_count), 32'd0);
        rst_n = 1'b1;
        step(10);

        // Idle after reset
        chk("idle_framing_err", 32'(framing_err), 32'd0);
        chk("idle_select_err", 32'(select_err), 32'd0);
        chk("idle_word_valid_cnt", 32'(wv_cnt), 32'd0);
        chk("idle_frame_done_cnt", 32'(fd_cnt), 32'd0);
        chk("idle_fcnt", 32'(frame_count), 32'd0);
        check_frame("idle_frame", 0, 2'd0);

        // Frame 1: column 0 lit in passes 0-2
        for (int p = 0; p < 4; p++) begin
            for (int r = 0; r < 16; r++) begin
                if (p == 3 && r == 15) chk("f1_no_done_before_64", 32'(fd_cnt), 32'd0);
                send_latch(mkw((p < 3) ? 16'h0001 : 16'h0000, 4'(r)));
            end
        end
        step(4);
        chk("f1_done_cnt", 32'(fd_cnt), 32'd1);
        chk("f1_fcnt", 32'(frame_count), 32'd1);
        chk("f1_word_valid_cnt", 32'(wv_cnt), 32'd64);
        chk("f1_last_word", word, 32'h0000_FFFE);
        chk("f1_framing_err", 32'(framing_err), 32'd0);
        chk("f1_select_err", 32'(select_err), 32'd0);
        check_frame("f1_pixels", 0, 2'd3);

        // 31-bit word: framing error, word still updates
        v31 = 32'h0001_7FFF;
        for (int i = 30; i >= 0; i--) send_bit(v31[i]);
        latch_pulse();
        chk("short_framing_err", 32'(framing_err), 32'd1);
        chk("short_select_err", 32'(select_err), 32'd0);
        chk("short_word", word, 32'h0001_7FFF);
        chk("short_word_model", word, tb_shreg);
        chk("short_word_valid_cnt", 32'(wv_cnt), 32'd65);
        pulse_err_clr();
        chk("short_err_clr", 32'(framing_err), 32'd0);

        // Bad cathode fields
        send_latch(32'h8000_FFFF);
        chk("nosel_select_err", 32'(select_err), 32'd1);
        chk("nosel_framing_err", 32'(framing_err), 32'd0);
        pulse_err_clr();
        chk("nosel_err_clr", 32'(select_err), 32'd0);
        send_latch(32'h8000_0000);
        chk("allsel_select_err", 32'(select_err), 32'd1);
        chk("allsel_word", word, 32'h8000_0000);
        pulse_err_clr();

        // Clear mid-word, then a fresh valid word (row 11, no anodes)
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        sclk = 1'b0;
        clear = 1'b0;
        tb_shreg = '0;
        step(4);
        clear = 1'b1;
        step(3);
        send_latch(32'h0000_FFEF);
        chk("clear_word", word, 32'h0000_FFEF);
        chk("clear_framing_err", 32'(framing_err), 32'd0);
        chk("clear_select_err", 32'(select_err), 32'd0);
        chk("frame_count_hold", 32'(frame_count), 32'd1);

        // Frame 2: one latch already counted; errored latches must not count
        for (int i = 0; i < 62; i++) begin
            send_latch(mkw((i < 16) ? 16'h8000 : 16'h0000, 4'(i % 16)));
        end
        chk("f2_no_done_at_63", 32'(fd_cnt), 32'd1);
        send_latch(mkw(16'h0000, 4'd14));
        step(4);
        chk("f2_done_cnt", 32'(fd_cnt), 32'd2);
        chk("f2_fcnt", 32'(frame_count), 32'd2);
        check_frame("f2_pixels", 15, 2'd1);

        // Reset mid-frame discards partial accumulation and counts
        for (int i = 0; i < 20; i++) send_latch(mkw(16'hFFFF, 4'(i % 16)));
        rst_n = 1'b0;
        step(2);
        chk("mid_reset_word", word, 32'h0);
        chk("mid_reset_fcnt", 32'(frame_count), 32'd0);
        rd_row = 4'd3;
        rd_col = 4'd15;
        #1;
        chk("mid_reset_pix", 32'(rd_pix), 32'd0);
        fd_base = fd_cnt;
        tb_shreg = '0;
        rst_n = 1'b1;
        step(5);
        for (int p = 0; p < 4; p++) begin
            for (int r = 0; r < 16; r++) begin
                if (p == 3 && r == 15) chk("f3_no_done_at_63", 32'(fd_cnt - fd_base), 32'd0);
                send_latch(mkw((p == 0) ? 16'h0002 : 16'h0000, 4'(r)));
            end
        end
        step(4);
        chk("f3_done_cnt", 32'(fd_cnt - fd_base), 32'd1);
        chk("f3_fcnt", 32'(frame_count), 32'd1);
        check_frame("f3_pixels", 1, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
